// File: rtl/host_cfg_pkg.sv
// Shared constants and types for the host configuration register file.
package host_cfg_pkg;

    localparam logic [7:0] ADDR_CTRL          = 8'h00;
    localparam logic [7:0] ADDR_ID            = 8'h01;
    localparam logic [7:0] ADDR_PORT_CFG_BASE = 8'h10;
    localparam logic [7:0] ADDR_PKT_CNT_BASE  = 8'h20;

    // Per-port windows are 16 words; the low nibble selects the port.
    localparam int unsigned WINDOW_W = 4;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_LOCK_BIT = 1;
    localparam int unsigned PORT_CFG_W    = 3;

    // Field order gives en at bit0 and prio at bits 2:1, matching the register layout.
    typedef struct packed {
        logic [1:0] prio;
        logic       en;
    } port_cfg_t;

endpackage

// File: rtl/host_cfg_rd_pipe.sv
// Fixed-latency read return pipeline carrying valid, payload and error per slot.
// side_err injects a non-read error into the output stage so it pulses one cycle after its access.
module host_cfg_rd_pipe #(
    parameter int unsigned PAYLOAD_W = 16,
    parameter int unsigned LAT       = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [PAYLOAD_W-1:0] in_data,
    input  logic                 in_err,
    input  logic                 side_err,
    output logic                 out_valid,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic                 out_err
);

    logic [LAT-1:0]       vld_q, vld_d;
    logic [LAT-1:0]       err_q, err_d;
    logic [PAYLOAD_W-1:0] dat_q [LAT];
    logic [PAYLOAD_W-1:0] dat_d [LAT];

    // Shift one slot per cycle; invalid slots carry zero data so the output is 0 when idle.
    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        dat_d[0] = '0;
        vld_d[0] = in_valid;
        err_d[0] = in_valid & in_err;
        if (in_valid) begin
            dat_d[0] = in_data;
        end
        for (int i = 1; i < int'(LAT); i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
        err_d[LAT-1] = err_d[LAT-1] | side_err;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            for (int i = 0; i < int'(LAT); i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_err   = err_q[LAT-1];
    assign out_data  = dat_q[LAT-1];

endmodule

// File: rtl/host_cfg_regfile.sv
// Host-side config/status register file for the NxN router: CTRL, ID, per-port config and packet counters.
// Optional HOST_CFG_PARITY_EN adds even parity on host write and read data.
module host_cfg_regfile
    import host_cfg_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 16,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned READ_LAT  = 2,
    parameter logic [15:0] DEV_ID    = 16'h5254
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   host_wr_n,
    input  logic                   host_rd_n,
    input  logic [ADDR_W-1:0]      host_addr,
    input  logic [DATA_W-1:0]      host_wdata,
`ifdef HOST_CFG_PARITY_EN
    input  logic                   host_wpar,
    output logic                   host_rpar,
`endif
    output logic [DATA_W-1:0]      host_rdata,
    output logic                   host_rvalid,
    output logic                   host_err,
    input  logic [NUM_PORTS-1:0]   pkt_done,
    output logic                   cfg_glb_en,
    output logic [NUM_PORTS-1:0]   cfg_port_en,
    output logic [2*NUM_PORTS-1:0] cfg_port_prio
);

    localparam int unsigned WIN_HI_W = ADDR_W - WINDOW_W;
`ifdef HOST_CFG_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned PAYLOAD_W = DATA_W + PAR_W;

    logic                 glb_en;
    logic                 lock;
    port_cfg_t            port_cfg [NUM_PORTS];
    logic [DATA_W-1:0]    pkt_cnt  [NUM_PORTS];

    logic                 wr_req, rd_req, collide, wr_ok, rd_ok;
    logic                 wpar_ok;
    logic [WINDOW_W-1:0]  idx;
    logic [WIN_HI_W-1:0]  win;
    logic                 idx_ok;
    logic                 hit_ctrl, hit_id, hit_pcfg, hit_pcnt, hit_any;
    logic                 wr_err;
    logic [DATA_W-1:0]    rd_data_c;
    logic [PAYLOAD_W-1:0] rd_payload;
    logic [PAYLOAD_W-1:0] pipe_data;
    logic                 unused_wdata;

    assign wr_req  = !host_wr_n;
    assign rd_req  = !host_rd_n;
    assign collide = wr_req && rd_req;
    assign wr_ok   = wr_req && !rd_req;
    assign rd_ok   = rd_req && !wr_req;

`ifdef HOST_CFG_PARITY_EN
    assign wpar_ok = (host_wpar == ^host_wdata);
`else
    assign wpar_ok = 1'b1;
`endif

    // Address decode; per-port windows beyond NUM_PORTS fall through as unmapped.
    assign idx      = host_addr[WINDOW_W-1:0];
    assign win      = host_addr[ADDR_W-1:WINDOW_W];
    assign idx_ok   = 32'(idx) < NUM_PORTS;
    assign hit_ctrl = (host_addr == ADDR_W'(ADDR_CTRL));
    assign hit_id   = (host_addr == ADDR_W'(ADDR_ID));
    assign hit_pcfg = (win == WIN_HI_W'(ADDR_PORT_CFG_BASE >> WINDOW_W)) && idx_ok;
    assign hit_pcnt = (win == WIN_HI_W'(ADDR_PKT_CNT_BASE >> WINDOW_W)) && idx_ok;
    assign hit_any  = hit_ctrl || hit_id || hit_pcfg || hit_pcnt;

    assign wr_err = wr_ok && (!wpar_ok || !(hit_ctrl || hit_pcfg) || (hit_pcfg && lock));

    assign unused_wdata = ^host_wdata[DATA_W-1:PORT_CFG_W];

    // Control and per-port config registers; lock is sticky until reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            glb_en <= 1'b0;
            lock   <= 1'b0;
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                port_cfg[p] <= '0;
            end
        end else if (wr_ok && wpar_ok) begin
            if (hit_ctrl) begin
                glb_en <= host_wdata[CTRL_EN_BIT];
                lock   <= lock | host_wdata[CTRL_LOCK_BIT];
            end
            if (hit_pcfg && !lock) begin
                for (int p = 0; p < int'(NUM_PORTS); p++) begin
                    if (idx == WINDOW_W'(p)) begin
                        port_cfg[p] <= port_cfg_t'(host_wdata[PORT_CFG_W-1:0]);
                    end
                end
            end
        end
    end

    // Saturating packet counters, cleared by a read; a same-cycle pkt_done restarts at 1.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                pkt_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (rd_ok && hit_pcnt && (idx == WINDOW_W'(p))) begin
                    pkt_cnt[p] <= pkt_done[p] ? DATA_W'(1) : '0;
                end else if (pkt_done[p] && (pkt_cnt[p] != '1)) begin
                    pkt_cnt[p] <= pkt_cnt[p] + DATA_W'(1);
                end
            end
        end
    end

    // Read data selection; unmapped addresses return zero.
    always_comb begin
        rd_data_c = '0;
        if (hit_ctrl) begin
            rd_data_c = DATA_W'({lock, glb_en});
        end else if (hit_id) begin
            rd_data_c = DATA_W'(DEV_ID);
        end else if (hit_pcfg || hit_pcnt) begin
            for (int p = 0; p < int'(NUM_PORTS); p++) begin
                if (idx == WINDOW_W'(p)) begin
                    rd_data_c = hit_pcfg ? DATA_W'(port_cfg[p]) : pkt_cnt[p];
                end
            end
        end
    end

`ifdef HOST_CFG_PARITY_EN
    assign rd_payload = {^rd_data_c, rd_data_c};
    assign host_rpar  = pipe_data[DATA_W];
`else
    assign rd_payload = rd_data_c;
`endif

    host_cfg_rd_pipe #(
        .PAYLOAD_W (PAYLOAD_W),
        .LAT       (READ_LAT)
    ) u_rd_pipe (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (rd_ok),
        .in_data   (rd_payload),
        .in_err    (!hit_any),
        .side_err  (collide || wr_err),
        .out_valid (host_rvalid),
        .out_data  (pipe_data),
        .out_err   (host_err)
    );

    assign host_rdata = pipe_data[DATA_W-1:0];
    assign cfg_glb_en = glb_en;

    always_comb begin
        cfg_port_en   = '0;
        cfg_port_prio = '0;
        for (int p = 0; p < int'(NUM_PORTS); p++) begin
            cfg_port_en[p]       = port_cfg[p].en;
            cfg_port_prio[2*p+:2] = port_cfg[p].prio;
        end
    end

endmodule

// File: tb/tb_host_cfg_regfile.sv
// Directed bench for host_cfg_regfile: register map, lock, counters, errors and read pipeline.
module tb_host_cfg_regfile;

    localparam int unsigned NP  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;
    localparam int unsigned LAT = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          host_wr_n, host_rd_n;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_rvalid, host_err;
    logic [NP-1:0] pkt_done;
    logic          cfg_glb_en;
    logic [NP-1:0] cfg_port_en;
    logic [2*NP-1:0] cfg_port_prio;
`ifdef HOST_CFG_PARITY_EN
    logic          host_wpar;
    logic          host_rpar;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    host_cfg_regfile #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .READ_LAT  (LAT),
        .DEV_ID    (16'h5254)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .host_wr_n     (host_wr_n),
        .host_rd_n     (host_rd_n),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
`ifdef HOST_CFG_PARITY_EN
        .host_wpar     (host_wpar),
        .host_rpar     (host_rpar),
`endif
        .host_rdata    (host_rdata),
        .host_rvalid   (host_rvalid),
        .host_err      (host_err),
        .pkt_done      (pkt_done),
        .cfg_glb_en    (cfg_glb_en),
        .cfg_port_en   (cfg_port_en),
        .cfg_port_prio (cfg_port_prio)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic wr_n, input logic rd_n, input logic [AW-1:0] a, input logic [DW-1:0] d);
        host_wr_n  = wr_n;
        host_rd_n  = rd_n;
        host_addr  = a;
        host_wdata = d;
`ifdef HOST_CFG_PARITY_EN
        host_wpar  = ^d;
`endif
    endtask

    task automatic idle_bus();
        drive(1'b1, 1'b1, '0, '0);
    endtask

    // Write at the next posedge; returns on the following negedge, where host_err is visible.
    task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b0, 1'b1, a, d);
        @(negedge clock);
        idle_bus();
    endtask

    // Read, confirm nothing returns early, then check the returned slot.
    task automatic read_chk(input string tag, input logic [AW-1:0] a,
                            input logic [DW-1:0] exp_d, input logic exp_e);
        drive(1'b1, 1'b0, a, '0);
        @(negedge clock);
        idle_bus();
        repeat (LAT - 1) begin
            chk({tag, "_early"}, 32'(host_rvalid), 32'd0);
            @(negedge clock);
        end
        chk({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
        chk({tag, "_rdata"},  32'(host_rdata),  32'(exp_d));
        chk({tag, "_err"},    32'(host_err),    32'(exp_e));
    endtask

    initial begin
        reset_n  = 1'b0;
        pkt_done = '0;
        idle_bus();
        repeat (3) @(negedge clock);
        chk("rst_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_err",    32'(host_err),    32'd0);
        chk("rst_rdata",  32'(host_rdata),  32'd0);
        chk("rst_glb",    32'(cfg_glb_en),  32'd0);
        chk("rst_pen",    32'(cfg_port_en), 32'd0);
        chk("rst_prio",   cfg_port_prio,    32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // ID readback, then the pulse must drop
        read_chk("id", 16'h0001, 16'h5254, 1'b0);
        @(negedge clock);
        chk("id_pulse_end", 32'(host_rvalid), 32'd0);
        chk("id_rdata_zero", 32'(host_rdata), 32'd0);

        // PORT_CFG[3] with junk in unused bits
        write_reg(16'h0013, 16'hFFF5);
        chk("pcfg3_err",  32'(host_err),    32'd0);
        chk("pcfg3_en",   32'(cfg_port_en), 32'h0008);
        chk("pcfg3_prio", cfg_port_prio,    32'h0000_0080);
        read_chk("pcfg3_rb", 16'h0013, 16'h0005, 1'b0);

        // Simultaneous strobes: error, no update, no read return
        drive(1'b0, 1'b0, 16'h0010, 16'h0007);
        @(negedge clock);
        idle_bus();
        chk("coll_err",    32'(host_err),    32'd1);
        chk("coll_rvalid", 32'(host_rvalid), 32'd0);
        chk("coll_pen",    32'(cfg_port_en), 32'h0008);
        @(negedge clock);
        chk("coll_rvalid2", 32'(host_rvalid), 32'd0);
        chk("coll_err_end", 32'(host_err),    32'd0);
        @(negedge clock);
        chk("coll_rvalid3", 32'(host_rvalid), 32'd0);

        // Writes to RO and unmapped addresses
        write_reg(16'h0001, 16'h1234);
        chk("ro_wr_err", 32'(host_err), 32'd1);
        write_reg(16'h0040, 16'h0001);
        chk("unmap_wr_err", 32'(host_err), 32'd1);
        read_chk("id_after_ro_wr", 16'h0001, 16'h5254, 1'b0);

        // Lock, then a dropped PORT_CFG write
        write_reg(16'h0000, 16'h0003);
        chk("lock_wr_err", 32'(host_err),   32'd0);
        chk("lock_glb",    32'(cfg_glb_en), 32'd1);
        write_reg(16'h0010, 16'h0001);
        chk("locked_pcfg_err", 32'(host_err),    32'd1);
        chk("locked_pcfg_pen", 32'(cfg_port_en), 32'h0008);
        @(negedge clock);
        chk("locked_err_pulse", 32'(host_err), 32'd0);
        write_reg(16'h0000, 16'h0000);
        chk("locked_ctrl_err", 32'(host_err),   32'd0);
        chk("locked_ctrl_glb", 32'(cfg_glb_en), 32'd0);
        read_chk("ctrl_sticky", 16'h0000, 16'h0002, 1'b0);

        // Five packets on port 2, then a read coinciding with a sixth
        repeat (5) begin
            pkt_done = 16'h0004;
            @(negedge clock);
            pkt_done = '0;
            @(negedge clock);
        end
        drive(1'b1, 1'b0, 16'h0022, '0);
        pkt_done = 16'h0004;
        @(negedge clock);
        idle_bus();
        pkt_done = '0;
        @(negedge clock);
        chk("cnt_rvalid", 32'(host_rvalid), 32'd1);
        chk("cnt_first",  32'(host_rdata),  32'd5);
        read_chk("cnt_second", 16'h0022, 16'h0001, 1'b0);
        read_chk("cnt_cleared", 16'h0022, 16'h0000, 1'b0);

        // Back-to-back reads: ID, PORT_CFG[0], unmapped
        drive(1'b1, 1'b0, 16'h0001, '0);
        @(negedge clock);
        drive(1'b1, 1'b0, 16'h0010, '0);
        @(negedge clock);
        chk("b2b0_rvalid", 32'(host_rvalid), 32'd1);
        chk("b2b0_rdata",  32'(host_rdata),  32'h5254);
        chk("b2b0_err",    32'(host_err),    32'd0);
        drive(1'b1, 1'b0, 16'h007F, '0);
        @(negedge clock);
        idle_bus();
        chk("b2b1_rvalid", 32'(host_rvalid), 32'd1);
        chk("b2b1_rdata",  32'(host_rdata),  32'h0000);
        chk("b2b1_err",    32'(host_err),    32'd0);
        @(negedge clock);
        chk("b2b2_rvalid", 32'(host_rvalid), 32'd1);
        chk("b2b2_rdata",  32'(host_rdata),  32'h0000);
        chk("b2b2_err",    32'(host_err),    32'd1);
        @(negedge clock);
        chk("b2b_done_rvalid", 32'(host_rvalid), 32'd0);
        chk("b2b_done_err",    32'(host_err),    32'd0);

        // Reset with a read in flight discards it and clears lock and config
        write_reg(16'h0000, 16'h0001);
        chk("pre_rst_glb", 32'(cfg_glb_en), 32'd1);
        drive(1'b1, 1'b0, 16'h0001, '0);
        @(negedge clock);
        idle_bus();
        reset_n = 1'b0;
        @(negedge clock);
        chk("midrst_rvalid", 32'(host_rvalid), 32'd0);
        chk("midrst_glb",    32'(cfg_glb_en),  32'd0);
        chk("midrst_pen",    32'(cfg_port_en), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("postrst_rvalid", 32'(host_rvalid), 32'd0);
        read_chk("postrst_ctrl", 16'h0000, 16'h0000, 1'b0);
        write_reg(16'h0010, 16'h0003);
        chk("unlocked_pcfg_err", 32'(host_err),    32'd0);
        chk("unlocked_pcfg_pen", 32'(cfg_port_en), 32'h0001);
        chk("unlocked_pcfg_prio", cfg_port_prio,   32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
